store_queue_fwd: RTL

Parametrised successor to the data-side store buffer. Holds speculative stores tagged with ROB index, marks them committed on ROB commit, and drains committed stores in order to the D-cache over a valid/ready handshake. Provides byte-granular store-to-load forwarding from the youngest matching stores, with partial-overlap conflict detection. Flushes uncommitted entries on exception. Sits in the memory stage between the ALU address path and the TLB/D-cache write port.

---
 rtl/riscv_mem_pkg.sv | 79 +++++++
 rtl/sq_forward_unit.sv | 52 +++++
 rtl/store_queue_fwd.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage types and helpers: funct3 encodings, the store-queue
// entry record, store lane placement and load extension.
package riscv_mem_pkg;

    // Load/store size encodings (stores use only B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Entry fields are sized for the widest supported configuration; a queue
    // with narrower ADDR_W / ROB_IDX_W zero-extends into them.
    localparam int SQ_ADDR_MAX_W = 64;
    localparam int SQ_WORD_W     = SQ_ADDR_MAX_W - 2;
    localparam int SQ_ROB_MAX_W  = 16;

    typedef struct packed {
        logic                    valid;
        logic                    committed;
        logic [SQ_WORD_W-1:0]    addr_word;
        logic [31:0]             data;
        logic [3:0]              be;
        logic [SQ_ROB_MAX_W-1:0] rob_idx;
    } sq_entry_t;

    function automatic logic store_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 1'b1;
            F3_H:    return ~off[0];
            F3_W:    return off == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << {off[1], 1'b0};
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_place(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] data);
        case (f3)
            F3_B:    return {24'b0, data[7:0]} << {off, 3'b000};
            F3_H:    return {16'b0, data[15:0]} << {off[1], 4'b0000};
            F3_W:    return data;
            default: return 32'b0;
        endcase
    endfunction

    // Bytes a load needs; zero means misaligned or unsupported size
    function automatic logic [3:0] load_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << off;
            F3_H, F3_HU: return off[0] ? 4'b0000 : (4'b0011 << {off[1], 1'b0});
            F3_W:        return (off == 2'b00) ? 4'b1111 : 4'b0000;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_BU:   return {24'b0, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_HU:   return {16'b0, s[15:0]};
            F3_W:    return word;
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/sq_forward_unit.sv
// Store-to-load forwarding: per requested byte, take the youngest valid entry
// covering it, then extend the assembled word for the load size.
module sq_forward_unit
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  sq_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_idx,
    input  logic                       load_valid,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic [2:0]                 load_funct3,
    output logic                       load_hit,
    output logic                       load_conflict,
    output logic [31:0]                load_data
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [SQ_WORD_W-1:0] load_word;
    logic [3:0]           req;
    logic [3:0]           covered;
    logic [31:0]          merged;
    logic [IDX_W-1:0]     idx;

    assign load_word = SQ_WORD_W'(load_addr[ADDR_W-1:2]);

    // Walk oldest to youngest so a younger match overwrites an older one
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req     = load_valid ? load_mask(load_funct3, load_addr[1:0]) : 4'b0000;
        covered = 4'b0000;
        merged  = 32'b0;
        idx     = head_idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + IDX_W'(i);
            if (entries[idx].valid && entries[idx].addr_word == load_word) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[idx].be[b] && req[b]) begin
                        covered[b]       = 1'b1;
                        merged[8*b +: 8] = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
        load_hit      = (req != 4'b0000) && (covered == req);
        load_conflict = (covered != 4'b0000) && (covered != req);
        load_data     = load_hit ? load_extend(load_funct3, load_addr[1:0], merged) : 32'b0;
    end

endmodule

// File: rtl/store_queue_fwd.sv
// Store queue: holds speculative stores, commits them by ROB tag, drains
// committed stores in order to the D-cache and forwards to younger loads.
module store_queue_fwd
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_store_valid,
    input  logic [ADDR_W-1:0]        in_store_addr,
    input  logic [31:0]              in_store_data,
    input  logic [2:0]               in_store_funct3,
    input  logic [ROB_IDX_W-1:0]     in_store_rob_idx,
    output logic                     out_store_ready,
    input  logic                     in_commit_valid,
    input  logic [ROB_IDX_W-1:0]     in_commit_rob_idx,
    input  logic                     in_flush,
    input  logic                     in_load_valid,
    input  logic [ADDR_W-1:0]        in_load_addr,
    input  logic [2:0]               in_load_funct3,
    output logic                     out_load_hit,
    output logic [31:0]              out_load_data,
    output logic                     out_load_conflict,
    output logic                     out_drain_valid,
    output logic [ADDR_W-1:0]        out_drain_addr,
    output logic [31:0]              out_drain_data,
    output logic [3:0]               out_drain_byte_en,
    input  logic                     in_drain_ready,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     out_empty,
    output logic                     out_misaligned
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    sq_entry_t          entries_q [DEPTH];
    sq_entry_t          entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]   committed_cnt;
    logic [IDX_W-1:0]   head_idx, tail_idx, commit_idx;
    logic               full, aligned, alloc, drain_fire, commit_hit;
    sq_entry_t          head_entry;

    assign head_idx   = head_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign full       = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
    assign aligned    = store_aligned(in_store_funct3, in_store_addr[1:0]);
    assign alloc      = in_store_valid && !full && aligned && !in_flush;
    assign head_entry = entries_q[head_idx];
    assign drain_fire = out_drain_valid && in_drain_ready;

    assign out_store_ready   = !full;
    assign out_misaligned    = in_store_valid && !aligned;
    assign out_count         = tail_q - head_q;
    assign out_empty         = (tail_q == head_q);
    assign out_drain_valid   = head_entry.valid && head_entry.committed;
    assign out_drain_addr    = out_drain_valid ? {head_entry.addr_word[ADDR_W-3:0], 2'b00} : '0;
    assign out_drain_data    = out_drain_valid ? head_entry.data : 32'b0;
    assign out_drain_byte_en = out_drain_valid ? head_entry.be : 4'b0000;

    // Count committed entries; they form a prefix starting at head
    always_comb begin
        committed_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            committed_cnt = committed_cnt + PTR_W'(entries_q[i].valid && entries_q[i].committed);
        end
    end

    // Next-state: commit, then drain, then flush (which wins over allocate)
    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        commit_hit = 1'b0;
        commit_idx = head_idx;

        if (in_commit_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                commit_idx = head_idx + IDX_W'(i);
                if (!commit_hit && entries_q[commit_idx].valid && !entries_q[commit_idx].committed &&
                    entries_q[commit_idx].rob_idx == SQ_ROB_MAX_W'(in_commit_rob_idx)) begin
                    entries_d[commit_idx].committed = 1'b1;
                    commit_hit                      = 1'b1;
                end
            end
        end

        if (drain_fire) begin
            entries_d[head_idx].valid     = 1'b0;
            entries_d[head_idx].committed = 1'b0;
            head_d                        = head_q + PTR_W'(1);
        end

        if (in_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!entries_d[i].committed) entries_d[i].valid = 1'b0;
            end
            tail_d = head_q + committed_cnt + PTR_W'(commit_hit);
        end else if (alloc) begin
            entries_d[tail_idx].valid     = 1'b1;
            entries_d[tail_idx].committed = 1'b0;
            entries_d[tail_idx].addr_word = SQ_WORD_W'(in_store_addr[ADDR_W-1:2]);
            entries_d[tail_idx].data      = lane_place(in_store_funct3, in_store_addr[1:0], in_store_data);
            entries_d[tail_idx].be        = store_be(in_store_funct3, in_store_addr[1:0]);
            entries_d[tail_idx].rob_idx   = SQ_ROB_MAX_W'(in_store_rob_idx);
            tail_d                        = tail_q + PTR_W'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            // NOTE: the entry array is reset, not just the pointers: valid bits must clear and drain/forward paths read entries directly.
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

    sq_forward_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fwd (
        .entries       (entries_q),
        .head_idx      (head_idx),
        .load_valid    (in_load_valid),
        .load_addr     (in_load_addr),
        .load_funct3   (in_load_funct3),
        .load_hit      (out_load_hit),
        .load_conflict (out_load_conflict),
        .load_data     (out_load_data)
    );

endmodule
